// File: rtl/tl_tx_pkg.sv
// Shared TX transaction-layer constants: request type codes, completion
// status codes and the Cpl (no data) header format/type fields.
package tl_tx_pkg;

  typedef enum logic [2:0] {
    TLP_MEMORY        = 3'b000,
    TLP_IO            = 3'b001,
    TLP_COMPLETION    = 3'b010,
    TLP_CONFIGURATION = 3'b011,
    TLP_MESSAGE       = 3'b100
  } tlp_typ_e;

  localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
  localparam logic [2:0] CPL_STATUS_CRS = 3'b010;
  localparam logic [2:0] CPL_STATUS_CA  = 3'b100;

  localparam logic [2:0] CPL_FMT_NO_DATA = 3'b000;
  localparam logic [4:0] CPL_TYPE        = 5'b01010;

  // Only MEM reads, IO and CFG expect a completion; every other code,
  // including the reserved 101-111 range, is handled as posted.
  function automatic logic is_non_posted(input logic [2:0] typ, input logic rw);
    return ((typ == TLP_MEMORY) && !rw) || (typ == TLP_IO) || (typ == TLP_CONFIGURATION);
  endfunction

endpackage

// File: rtl/tl_tx_ur_cpl_gen_if.sv
// Request-in / completion-out bundle of the UR completion generator.
interface tl_tx_ur_cpl_gen_if #(
    parameter int ADDRESS_WIDTH = 64
);
    // Handshake: a request transfers on a clock edge where req_valid & req_ready,
    // a header on an edge where cpl_valid & cpl_ready; cpl_hdr holds while stalled.
    logic                     req_valid;
    logic                     req_ready;
    logic                     ur_error;
    logic [2:0]               req_typ;
    logic                     req_read_write;
    logic [15:0]              req_requester_id;
    logic [9:0]               req_tag;
    logic [2:0]               req_tc;
    logic [2:0]               req_attr;
    logic [9:0]               req_length;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [15:0]              completer_id;
    logic                     cpl_valid;
    logic                     cpl_ready;
    logic [95:0]              cpl_hdr;
    logic                     err_posted_ur;
    logic [15:0]              ur_cpl_count;
    logic                     overflow;

    modport master (
        output req_valid, ur_error, req_typ, req_read_write, req_requester_id,
               req_tag, req_tc, req_attr, req_length, req_address, completer_id,
               cpl_ready,
        input  req_ready, cpl_valid, cpl_hdr, err_posted_ur, ur_cpl_count, overflow
    );

    modport slave (
        input  req_valid, ur_error, req_typ, req_read_write, req_requester_id,
               req_tag, req_tc, req_attr, req_length, req_address, completer_id,
               cpl_ready,
        output req_ready, cpl_valid, cpl_hdr, err_posted_ur, ur_cpl_count, overflow
    );
endinterface

// File: rtl/tl_tx_ur_cpl_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the read port shows the head
// entry combinationally from storage and reads zero while empty.
module tl_tx_ur_cpl_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/tl_tx_ur_cpl_gen.sv
// Builds UR Completion-without-Data headers for rejected non-posted requests,
// queues them for the TX arbiter and flags posted UR failures.
module tl_tx_ur_cpl_gen
    import tl_tx_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 64
) (
    input logic               clk,
    input logic               rst,
    tl_tx_ur_cpl_gen_if.slave bus
);
    logic        non_posted, ur_hit, push, pop, mem_rd;
    logic        fifo_full, fifo_empty;
    logic [95:0] hdr_new, head_hdr;
    logic [31:0] dw0, dw1, dw2;
    logic [11:0] byte_count;
    logic [6:0]  lower_addr;
    logic        err_posted_q, err_posted_d;
    logic        overflow_q, overflow_d;
    logic [15:0] cnt_q, cnt_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.req_address[ADDRESS_WIDTH-1:7], bus.req_address[1:0]};

    always_comb begin
        non_posted   = is_non_posted(bus.req_typ, bus.req_read_write);
        ur_hit       = bus.req_valid && bus.ur_error;
        push         = ur_hit && non_posted && !fifo_full;
        pop          = !fifo_empty && bus.cpl_ready;
        err_posted_d = ur_hit && !non_posted;
        overflow_d   = overflow_q || (ur_hit && non_posted && fifo_full);
        cnt_d        = (pop && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    // Byte count and lower address only carry request data for MEM reads.
    always_comb begin
        mem_rd     = (bus.req_typ == TLP_MEMORY) && !bus.req_read_write;
        byte_count = mem_rd ? {bus.req_length, 2'b00} : 12'd4;
        lower_addr = mem_rd ? {bus.req_address[6:2], 2'b00} : 7'd0;
        dw0 = {CPL_FMT_NO_DATA, CPL_TYPE, bus.req_tag[9], bus.req_tc, bus.req_tag[8],
               bus.req_attr[2], 2'b00, 1'b0, 1'b0, bus.req_attr[1:0], 2'b00, 10'd0};
        dw1 = {bus.completer_id, CPL_STATUS_UR, 1'b0, byte_count};
        dw2 = {bus.req_requester_id, bus.req_tag[7:0], 1'b0, lower_addr};
        hdr_new = {dw0, dw1, dw2};
    end

    tl_tx_ur_cpl_fifo #(
        .WIDTH (96),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (hdr_new),
        .pop_i   (pop),
        .rdata_o (head_hdr),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_posted_q <= 1'b0;
            overflow_q   <= 1'b0;
            cnt_q        <= 16'd0;
        end else begin
            err_posted_q <= err_posted_d;
            overflow_q   <= overflow_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready     = !fifo_full;
    assign bus.cpl_valid     = !fifo_empty;
    assign bus.cpl_hdr       = head_hdr;
    assign bus.err_posted_ur = err_posted_q;
    assign bus.overflow      = overflow_q;
    assign bus.ur_cpl_count  = cnt_q;
endmodule
